card_dealer: RTL and testbench

- Upstream stage of the hand evaluator; produces the nine dealt cards consumed by the per-card processors.
- Card slots: 1–2 are player 1's hole cards, 3–4 are player 2's, 5–9 are the community cards.
- Takes a free-running 16-bit random word each cycle and accepts only valid, not-yet-dealt card codes. Each code is {suit[1:0], rank[3:0]}, rank 1..13.
- Guarantees nine distinct cards, using a deterministic fallback scan if the random source stalls, then raises done.

---
 rtl/card_dealer.sv | 121 ++++++++++++
 tb/tb_card_dealer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: deals nine distinct card codes {suit[1:0], rank[3:0]} from a
// free-running random word, falling back to a linear scan of the code space
// whenever the random source keeps producing unusable values.
module card_dealer #(
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] rand_in,
    output logic [5:0]  card1_num,
    output logic [5:0]  card2_num,
    output logic [5:0]  card3_num,
    output logic [5:0]  card4_num,
    output logic [5:0]  card5_num,
    output logic [5:0]  card6_num,
    output logic [5:0]  card7_num,
    output logic [5:0]  card8_num,
    output logic [5:0]  card9_num,
    output logic        busy,
    output logic        done,
    output logic [7:0]  reject_count
);

    typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

    // Last try index before the fallback scan kicks in.
    localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

    state_t          state, state_nx;
    logic [8:0][5:0] cards;
    logic [63:0]     used;
    logic [3:0]      slot;
    logic [7:0]      tries;
    logic [5:0]      scan_ptr;

    logic       start_ok;
    logic [5:0] cand;
    logic       cand_ok;
    logic       accept;
    logic       last_slot;
    logic       tries_hit;

    // Candidate comes from the random word while drawing, from the scan
    // pointer while scanning; the same validity rule applies to both.
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign cand      = (state == SCAN) ? scan_ptr : rand_in[5:0];
    assign cand_ok   = (cand[3:0] >= 4'd1) && (cand[3:0] <= 4'd13) && !used[cand];
    assign accept    = (state == DRAW || state == SCAN) && cand_ok;
    assign last_slot = (slot == 4'd8);
    assign tries_hit = (state == DRAW) && !cand_ok && (tries == TRY_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state selection; start is only honoured when not dealing.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = DRAW;
            DRAW: begin
                if (accept)         state_nx = last_slot ? DONE : DRAW;
                else if (tries_hit) state_nx = SCAN;
            end
            SCAN: if (accept) state_nx = last_slot ? DONE : DRAW;
            DONE: if (start) state_nx = DRAW;
            default: state_nx = IDLE;
        endcase
    end

    // Deal datapath: clear on start, fill slots on accept, count rejects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cards        <= '0;
            used         <= '0;
            slot         <= '0;
            tries        <= '0;
            scan_ptr     <= '0;
            reject_count <= '0;
        end else if (start_ok) begin
            cards        <= '0;
            used         <= '0;
            slot         <= '0;
            tries        <= '0;
            reject_count <= '0;
        end else if (accept) begin
            cards[slot] <= cand;
            used[cand]  <= 1'b1;
            slot        <= slot + 4'd1;
            tries       <= '0;
        end else if (state == DRAW) begin
            if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
            if (tries_hit) begin
                tries    <= '0;
                scan_ptr <= '0;
            end else begin
                tries <= tries + 8'd1;
            end
        end else if (state == SCAN) begin
            // At most eight codes are used, so a hit always precedes 63.
            scan_ptr <= scan_ptr + 6'd1;
        end
    end

    assign card1_num = cards[0];
    assign card2_num = cards[1];
    assign card3_num = cards[2];
    assign card4_num = cards[3];
    assign card5_num = cards[4];
    assign card6_num = cards[5];
    assign card7_num = cards[6];
    assign card8_num = cards[7];
    assign card9_num = cards[8];

    assign busy = (state == DRAW) || (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: three instances (default, short and long try
// limits) share clock, reset and random word; each has its own start.
module tb_card_dealer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [15:0]     rand_in;
    logic            start_a, start_b, start_c;
    logic [8:0][5:0] ca, cb, cc;
    logic            busy_a, busy_b, busy_c;
    logic            done_a, done_b, done_c;
    logic [7:0]      rc_a, rc_b, rc_c;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q [$];

    card_dealer #(.MAX_TRIES(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rand_in(rand_in),
        .card1_num(ca[0]), .card2_num(ca[1]), .card3_num(ca[2]),
        .card4_num(ca[3]), .card5_num(ca[4]), .card6_num(ca[5]),
        .card7_num(ca[6]), .card8_num(ca[7]), .card9_num(ca[8]),
        .busy(busy_a), .done(done_a), .reject_count(rc_a)
    );

    card_dealer #(.MAX_TRIES(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rand_in(rand_in),
        .card1_num(cb[0]), .card2_num(cb[1]), .card3_num(cb[2]),
        .card4_num(cb[3]), .card5_num(cb[4]), .card6_num(cb[5]),
        .card7_num(cb[6]), .card8_num(cb[7]), .card9_num(cb[8]),
        .busy(busy_b), .done(done_b), .reject_count(rc_b)
    );

    card_dealer #(.MAX_TRIES(255)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .rand_in(rand_in),
        .card1_num(cc[0]), .card2_num(cc[1]), .card3_num(cc[2]),
        .card4_num(cc[3]), .card5_num(cc[4]), .card6_num(cc[5]),
        .card7_num(cc[6]), .card8_num(cc[7]), .card9_num(cc[8]),
        .busy(busy_c), .done(done_c), .reject_count(rc_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one random word for one cycle; queue it if it should be dealt.
    task automatic draw(input logic [5:0] v, input bit acc);
        rand_in = {10'd0, v};
        if (acc) exp_q.push_back(v);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (ca !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || rc_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_init cards=%h busy=%b done=%b rc=%0d (want all 0)", ca, busy_a, done_a, rc_a);
        end
        tick();
        rst = 1'b1;
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        draw(6'h01, 1'b0);
        draw(6'h00, 1'b0);
        draw(6'h02, 1'b0);
        checks++;
        if (busy_a !== 1'b1 || ca[0] !== 6'h01 || ca[1] !== 6'h02 || rc_a !== 8'd1) begin
            failures++;
            $display("FAIL reset_pre busy=%b c1=%h c2=%h rc=%0d (want 1 01 02 1)", busy_a, ca[0], ca[1], rc_a);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ca !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || rc_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid cards=%h busy=%b done=%b rc=%0d (want all 0)", ca, busy_a, done_a, rc_a);
        end
        exp_q.delete();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_clean_deal();
        logic [5:0] vals [9] = '{6'h01, 6'h02, 6'h03, 6'h11, 6'h12, 6'h21, 6'h2D, 6'h31, 6'h3D};
        logic [5:0] e;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            draw(vals[i], 1'b1);
            if (i == 0) begin
                checks++;
                if (ca[0] !== 6'h01 || ca[1] !== 6'h00) begin
                    failures++;
                    $display("FAIL clean_first c1=%h c2=%h (want 01 00)", ca[0], ca[1]);
                end
            end
            if (i == 7) begin
                checks++;
                if (done_a !== 1'b0 || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL clean_early done=%b busy=%b (want 0 1)", done_a, busy_a);
                end
            end
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || rc_a !== 8'd0) begin
            failures++;
            $display("FAIL clean_done done=%b busy=%b rc=%0d (want 1 0 0)", done_a, busy_a, rc_a);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (ca[i] !== e) begin
                failures++;
                $display("FAIL clean_card%0d got=%h want=%h", i + 1, ca[i], e);
            end
        end
    endtask

    task automatic test_rejections();
        logic [5:0] vals [14] = '{6'h00, 6'h0E, 6'h0F, 6'h05, 6'h05, 6'h05, 6'h06,
                                  6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
        bit         accs [14] = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic [5:0] e;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 0; i < 14; i++) begin
            // Slot 6 carries 0x45, which aliases the already-used 0x05.
            if (i == 5) begin
                rand_in = 16'h0045;
                tick();
            end else begin
                draw(vals[i], accs[i]);
            end
            if (i == 2) begin
                checks++;
                if (ca[0] !== 6'h00 || rc_a !== 8'd3) begin
                    failures++;
                    $display("FAIL rej_partial c1=%h rc=%0d (want 00 3)", ca[0], rc_a);
                end
            end
        end
        checks++;
        if (done_a !== 1'b1 || rc_a !== 8'd5) begin
            failures++;
            $display("FAIL rej_done done=%b rc=%0d (want 1 5)", done_a, rc_a);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (ca[i] !== e) begin
                failures++;
                $display("FAIL rej_card%0d got=%h want=%h", i + 1, ca[i], e);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [5:0] e;
        start_a = 1'b1; tick(); start_a = 1'b0;
        draw(6'h01, 1'b1);
        draw(6'h00, 1'b0);
        draw(6'h02, 1'b1);
        start_a = 1'b1;
        draw(6'h14, 1'b1);
        start_a = 1'b0;
        for (int i = 0; i < 6; i++) draw(6'h15 + 6'(i), 1'b1);
        tick();
        tick();
        checks++;
        if (done_a !== 1'b1 || rc_a !== 8'd1) begin
            failures++;
            $display("FAIL busy_done done=%b rc=%0d (want 1 1)", done_a, rc_a);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (ca[i] !== e) begin
                failures++;
                $display("FAIL busy_card%0d got=%h want=%h", i + 1, ca[i], e);
            end
        end
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || ca !== '0 || rc_a !== 8'd0) begin
            failures++;
            $display("FAIL restart done=%b busy=%b cards=%h rc=%0d (want 0 1 0 0)", done_a, busy_a, ca, rc_a);
        end
        for (int i = 0; i < 9; i++) draw(6'h31 + 6'(i), 1'b1);
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL restart_done done=%b (want 1)", done_a);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (ca[i] !== e) begin
                failures++;
                $display("FAIL restart_card%0d got=%h want=%h", i + 1, ca[i], e);
            end
        end
    endtask

    task automatic test_stall();
        logic [5:0] e;
        int n;
        rand_in = 16'h0001;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 1; i <= 9; i++) exp_q.push_back(6'(i));
        n = 0;
        while (!done_b && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done_b !== 1'b1) begin
            failures++;
            $display("FAIL stall_timeout done=%b after %0d cycles (want 1)", done_b, n);
        end
        checks++;
        if (rc_b !== 8'd32 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL stall_rc rc=%0d busy=%b (want 32 0)", rc_b, busy_b);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (cb[i] !== e) begin
                failures++;
                $display("FAIL stall_card%0d got=%h want=%h", i + 1, cb[i], e);
            end
        end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        start_c = 1'b1; tick(); start_c = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            for (int k = 0; k < 200; k++) draw(6'h00, 1'b0);
            checks++;
            if (rc_c !== ((s == 1) ? 8'd200 : 8'd255) || busy_c !== 1'b1) begin
                failures++;
                $display("FAIL sat_rc%0d rc=%0d busy=%b (want %0d 1)", s, rc_c, busy_c, (s == 1) ? 200 : 255);
            end
            draw(6'(s), 1'b1);
        end
        for (int s = 3; s <= 9; s++) draw(6'(s), 1'b1);
        checks++;
        if (done_c !== 1'b1 || rc_c !== 8'd255) begin
            failures++;
            $display("FAIL sat_done done=%b rc=%0d (want 1 255)", done_c, rc_c);
        end
        for (int i = 0; i < 9; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
            checks++;
            if (cc[i] !== e) begin
                failures++;
                $display("FAIL sat_card%0d got=%h want=%h", i + 1, cc[i], e);
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        rand_in = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        test_reset();
        test_clean_deal();
        test_rejections();
        test_start_while_busy();
        test_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
